// File: rtl/fp_relu_grad.sv
// fp_relu_grad: backward ReLU gate, masks stored in a FIFO on the forward pass, applied to gradients via a 2-stage pipeline
module fp_relu_grad #(
  parameter int EXP   = 4,
  parameter int MANT  = 4,
  parameter int WIDTH = 1 + EXP + MANT,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       clock_sreset,
  input  logic                       fwd_valid,
  input  logic [WIDTH-1:0]           fwd_data,
  output logic                       fwd_ready,
  input  logic                       bwd_valid,
  input  logic [WIDTH-1:0]           bwd_grad,
  output logic                       bwd_ready,
  output logic                       result_valid,
  output logic [WIDTH-1:0]           result,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [DEPTH-1:0] mask_mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic fwd_acc, bwd_acc, mask_bit;
  logic s1_valid, s1_mask;
  logic [WIDTH-1:0] s1_grad;
  assign fwd_ready = count != CW'(DEPTH);
  assign bwd_ready = count != '0;
  assign fwd_acc = fwd_valid & fwd_ready;
  assign bwd_acc = bwd_valid & bwd_ready;
  assign mask_bit = ~fwd_data[WIDTH-1] & |fwd_data[WIDTH-2:0];
  always_ff @(posedge clock)
    if (fwd_acc) mask_mem[wr_ptr] <= mask_bit;
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      s1_valid <= 1'b0;
      s1_mask <= 1'b0;
      s1_grad <= '0;
      result_valid <= 1'b0;
      result <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(fwd_acc);
      rd_ptr <= rd_ptr + AW'(bwd_acc);
      count <= count + CW'(fwd_acc) - CW'(bwd_acc);
      overflow <= overflow | (fwd_valid & ~fwd_ready);
      underflow <= underflow | (bwd_valid & ~bwd_ready);
      s1_valid <= bwd_acc;
      if (bwd_acc) begin
        s1_mask <= mask_mem[rd_ptr];
        s1_grad <= bwd_grad;
      end
      result_valid <= s1_valid;
      if (s1_valid) result <= s1_mask ? s1_grad : '0;
    end
  end
endmodule

// File: tb/tb_fp_relu_grad.sv
// tb_fp_relu_grad: directed and randomized checks of fp_relu_grad against a queue-based reference model
module tb_fp_relu_grad;
  localparam int EXP = 4, MANT = 4, WIDTH = 9, DEPTH = 16, CW = $clog2(DEPTH+1);
  logic clock = 0, clock_sreset = 1;
  logic fwd_valid = 0, bwd_valid = 0;
  logic [WIDTH-1:0] fwd_data = '0, bwd_grad = '0;
  logic fwd_ready, bwd_ready, result_valid, overflow, underflow;
  logic [WIDTH-1:0] result;
  logic [CW-1:0] count;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct {int due; logic [WIDTH-1:0] v;} exp_t;
  bit mq[$];
  exp_t eq[$];
  bit m_ov, m_uf;
  logic [WIDTH-1:0] last_res = '0;

  fp_relu_grad #(.EXP(EXP), .MANT(MANT), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .clock_sreset(clock_sreset),
    .fwd_valid(fwd_valid), .fwd_data(fwd_data), .fwd_ready(fwd_ready),
    .bwd_valid(bwd_valid), .bwd_grad(bwd_grad), .bwd_ready(bwd_ready),
    .result_valid(result_valid), .result(result), .count(count),
    .overflow(overflow), .underflow(underflow));

  always #5 clock = ~clock;

  function automatic bit mask_of(logic [WIDTH-1:0] d);
    int v = int'(d);
    return (v / (1 << (WIDTH-1))) == 0 && (v % (1 << (WIDTH-1))) != 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle(bit fv, logic [WIDTH-1:0] fd, bit bv, logic [WIDTH-1:0] bg);
    bit fr, br, m;
    exp_t e;
    fwd_valid = fv; fwd_data = fd; bwd_valid = bv; bwd_grad = bg;
    fr = mq.size() != DEPTH;
    br = mq.size() != 0;
    @(posedge clock);
    cyc++;
    if (clock_sreset) begin
      mq.delete(); eq.delete(); m_ov = 0; m_uf = 0; last_res = '0;
    end else begin
      if (bv && br) begin
        m = mq.pop_front();
        e.due = cyc + 1;
        e.v = m ? bg : '0;
        eq.push_back(e);
      end else if (bv) m_uf = 1;
      if (fv && fr) mq.push_back(mask_of(fd));
      else if (fv) m_ov = 1;
    end
    #1;
    chk("count", 32'(count), 32'(mq.size()));
    chk("fwd_ready", 32'(fwd_ready), 32'(mq.size() != DEPTH));
    chk("bwd_ready", 32'(bwd_ready), 32'(mq.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_uf));
    if (eq.size() != 0 && eq[0].due == cyc) begin
      e = eq.pop_front();
      last_res = e.v;
      chk("result_valid", 32'(result_valid), 32'd1);
    end else chk("result_valid", 32'(result_valid), 32'd0);
    chk("result", 32'(result), 32'(last_res));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, '0);
  endtask

  task automatic do_reset();
    clock_sreset = 1;
    cycle(0, '0, 0, '0);
    clock_sreset = 0;
  endtask

  initial begin
    #1;
    do_reset();
    cycle(1, 9'h070, 0, '0);
    cycle(0, '0, 1, 9'h180);
    chk("r031_not_yet", 32'(result_valid), 32'd0);
    idle(1);
    idle(1);
    chk("r031_result", 32'(result), 32'h180);
    cycle(1, 9'h170, 0, '0);
    cycle(1, 9'h000, 0, '0);
    cycle(1, 9'h100, 0, '0);
    cycle(1, 9'h060, 0, '0);
    for (int i = 0; i < 4; i++) cycle(0, '0, 1, 9'h060);
    idle(1);
    idle(1);
    chk("r032_last", 32'(result), 32'h060);
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, WIDTH'($urandom), 0, '0);
    chk("r033_full", 32'(count), 32'd16);
    cycle(1, 9'h070, 0, '0);
    chk("r033_ovf", 32'(overflow), 32'd1);
    cycle(0, '0, 1, 9'h055);
    chk("r033_read", 32'(count), 32'd15);
    idle(2);
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, WIDTH'($urandom), 0, '0);
    cycle(1, 9'h070, 1, 9'h033);
    chk("r034_count", 32'(count), 32'd15);
    chk("r034_ovf", 32'(overflow), 32'd1);
    idle(2);
    do_reset();
    cycle(1, 9'h070, 1, 9'h044);
    chk("r035_uf", 32'(underflow), 32'd1);
    chk("r035_count", 32'(count), 32'd1);
    idle(3);
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 9'h070, 0, '0);
    cycle(0, '0, 1, 9'h011);
    cycle(0, '0, 1, 9'h022);
    do_reset();
    chk("r036_count", 32'(count), 32'd0);
    chk("r036_rv", 32'(result_valid), 32'd0);
    chk("r036_res", 32'(result), 32'd0);
    idle(3);
    for (int p = 0; p < 4; p++) begin
      int fb = (p % 2 == 0) ? 75 : 35;
      int bb = (p % 2 == 0) ? 35 : 75;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 299) == 0) do_reset();
        else cycle($urandom_range(0, 99) < fb, WIDTH'($urandom),
                   $urandom_range(0, 99) < bb, WIDTH'($urandom));
      end
    end
    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_relu_grad.md
FP_RELU_GRAD -- requirements
Module: fp_relu_grad

Interface
REQ-001 Parameters SHALL be: EXP, default 4, exponent bits; MANT, default 4, mantissa bits; WIDTH, default 1+EXP+MANT, word width; DEPTH, default 16, mask buffer entries (power of 2, >=2).
REQ-002 Port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port clock_sreset  in  1  synchronous active-high reset.
REQ-004 Port fwd_valid  in  1  forward (pre-ReLU) activation present.
REQ-005 Port fwd_data  in  WIDTH  forward activation, format {sign, exp, mant}, no denorm/NaN/inf.
REQ-006 Port fwd_ready  out  1  mask buffer can accept an entry.
REQ-007 Port bwd_valid  in  1  upstream gradient present.
REQ-008 Port bwd_grad  in  WIDTH  upstream gradient, same format.
REQ-009 Port bwd_ready  out  1  a stored mask is available.
REQ-010 Port result_valid  out  1  result holds a valid gated gradient.
REQ-011 Port result  out  WIDTH  backward ReLU gradient.
REQ-012 Port count  out  $clog2(DEPTH+1)  stored mask entries.
REQ-013 Port overflow  out  1  sticky: forward word dropped while full.
REQ-014 Port underflow  out  1  sticky: gradient dropped while empty.

Function
REQ-015 Mask bit SHALL be 1 iff fwd_data sign=0 and exp/mant field nonzero; +0 and -0 SHALL give 0.
REQ-016 fwd_ready SHALL equal (count != DEPTH); bwd_ready SHALL equal (count != 0); both derived from registered count only.
REQ-017 Forward accept (fwd_valid & fwd_ready) SHALL write the mask bit at write pointer, pointer +1 modulo DEPTH.
REQ-018 Backward accept (bwd_valid & bwd_ready) SHALL read the oldest mask bit (FIFO order), read pointer +1 modulo DEPTH.
REQ-019 Same-cycle forward and backward accept SHALL leave count unchanged; count otherwise +1 on write only, -1 on read only.
REQ-020 No bypass: a mask written in cycle N SHALL not be readable before cycle N+1.
REQ-021 At full, a simultaneous read SHALL be accepted and the write refused (fwd_ready=0 that cycle).
REQ-022 Pipeline stage 1 SHALL register bwd_grad, read mask bit and accept flag; stage 2 SHALL register result and result_valid.
REQ-023 Latency SHALL be exactly 2 cycles from backward accept to result_valid=1; one result per accept, no stalls, full throughput.
REQ-024 result SHALL be bwd_grad bit-exact (any sign) when mask=1, all zeros (+0) when mask=0.
REQ-025 result SHALL hold its last value while result_valid=0.
REQ-026 overflow SHALL set when fwd_valid=1 and fwd_ready=0; underflow SHALL set when bwd_valid=1 and bwd_ready=0; both clear only on reset.
REQ-027 Dropped words SHALL not alter pointers, count or pipeline.

Reset
REQ-028 While clock_sreset=1: pointers, count, overflow, underflow, pipeline valids SHALL clear to 0; result SHALL be 0; fwd_ready=1, bwd_ready=0 in the following cycle.
REQ-029 Reset mid-operation SHALL discard buffered masks and in-flight results; result_valid SHALL be 0 in the cycle after reset is sampled.
REQ-030 Mask storage contents need not be reset.

Verification (EXP=4, MANT=4)
REQ-031 Write fwd 9'h070 (+1.0), then bwd 9'h180 (-2.0) -> result 9'h180, result_valid exactly 2 cycles after bwd accept.
REQ-032 Write fwd 9'h170, 9'h000, 9'h100, 9'h060; four bwd 9'h060 back-to-back -> results 9'h000, 9'h000, 9'h000, 9'h060 on consecutive cycles.
REQ-033 Write 16 forwards -> count=16, fwd_ready=0; 17th fwd_valid -> overflow=1, count stays 16; one read -> count 15.
REQ-034 At count=16, simultaneous fwd and bwd valid -> read accepted, write refused, overflow=1, count=15.
REQ-035 bwd_valid at reset-empty -> underflow=1, no result_valid; same-cycle first write -> no bypass, count=1.
REQ-036 Assert reset with 5 stored masks and 2 results in flight -> count=0, result_valid=0, result=0, flags clear next cycle.
